// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: op encodings, FSM states and partial-product helpers
// shared by the RV32M multiply sequencer.
package mul_seq_pkg;

    localparam int PP_COUNT = 4;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_COLLECT,
        S_FIX,
        S_DONE
    } state_e;

    // Weight of partial product k: aL*bL, aL*bH, aH*bL, aH*bH.
    function automatic logic [63:0] pp_term(input logic [1:0]  k,
                                            input logic [31:0] p);
        logic [63:0] w_full;
        logic [63:0] w_res;
        w_full = {32'b0, p};
        unique case (k)
            2'd0:    w_res = w_full;
            2'd3:    w_res = w_full << 32;
            default: w_res = w_full << 16;
        endcase
        return w_res;
    endfunction

endpackage

// File: rtl/mul_hi_fixup.sv
// mul_hi_fixup: turns the high word of an unsigned 32x32 product into
// the signed/signed or signed/unsigned high word (mod 2^32).
module mul_hi_fixup
    import mul_seq_pkg::*;
(
    input  logic [31:0] i_hi,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  op_e         i_op,
    output logic [31:0] o_hi
);

    logic [31:0] w_corr_a;
    logic [31:0] w_corr_b;

    assign w_corr_a = i_a[31] ? i_b : 32'b0;
    assign w_corr_b = i_b[31] ? i_a : 32'b0;

    always_comb begin
        o_hi = i_hi;
        unique case (i_op)
            OP_MULH:   o_hi = i_hi - w_corr_a - w_corr_b;
            OP_MULHSU: o_hi = i_hi - w_corr_a;
            default:   o_hi = i_hi;
        endcase
    end

endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: drives a shared registered 32x32 multiplier for RV32M MUL/MULH*.
// Optional MUL_FUSE_EN: a MUL matching the last MULH* operands reuses its low word.
module mul_sequencer
    import mul_seq_pkg::*;
#(
    parameter int MUL_LAT = 1,
    parameter int TAG_W   = 5
) (
    input  logic             CLK_0,
    input  logic             RESETN_0,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    output logic             mul_ce,
    input  logic [31:0]      mul_p
);

    localparam int CNT_W = $clog2(PP_COUNT + MUL_LAT + 1);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e           r_state;
    state_e           w_next;
    op_e              r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_res;
    logic [TAG_W-1:0] r_tag;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_acc;

    logic             w_accept;
    logic             w_hit;
    logic             w_cap;
    logic             w_issue;
    logic [CNT_W-1:0] w_n_issue;
    logic [CNT_W-1:0] w_last;
    logic [1:0]       w_k;
    logic [31:0]      w_fix_hi;
    logic [31:0]      w_fuse_lo;

    assign w_accept  = (r_state == S_IDLE) && req_valid && !flush;
    assign w_n_issue = (r_op == OP_MUL) ? ONE : CNT_W'(PP_COUNT);
    assign w_last    = w_n_issue + LAT;
    assign w_issue   = (r_state == S_ISSUE) && !w_hit;
    // Products issued k cycles ago surface MUL_LAT cycles later.
    assign w_k       = 2'(r_cnt - LAT);
    assign w_cap     = (w_issue || r_state == S_COLLECT) && (r_cnt >= LAT);

`ifdef MUL_FUSE_EN
    logic [31:0] r_fz_a;
    logic [31:0] r_fz_b;
    logic [31:0] r_fz_lo;
    logic        r_fz_v;
    logic        r_hit;

    always_ff @(posedge CLK_0 or negedge RESETN_0) begin
        if (!RESETN_0) begin
            r_fz_a  <= '0;
            r_fz_b  <= '0;
            r_fz_lo <= '0;
            r_fz_v  <= 1'b0;
            r_hit   <= 1'b0;
        end else if (flush) begin
            r_fz_v <= 1'b0;
            r_hit  <= 1'b0;
        end else begin
            if (w_accept)
                r_hit <= (req_op == OP_MUL) && r_fz_v &&
                         (req_rs1 == r_fz_a) && (req_rs2 == r_fz_b);
            if (r_state == S_FIX) begin
                r_fz_a  <= r_a;
                r_fz_b  <= r_b;
                r_fz_lo <= r_acc[31:0];
                r_fz_v  <= 1'b1;
            end
        end
    end

    assign w_hit     = r_hit && (r_state == S_ISSUE);
    assign w_fuse_lo = r_fz_lo;
`else
    assign w_hit     = 1'b0;
    assign w_fuse_lo = '0;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:
                if (w_accept) w_next = S_ISSUE;
            S_ISSUE:
                if (w_hit) w_next = S_DONE;
                else if (r_cnt == w_n_issue - ONE) w_next = S_COLLECT;
            S_COLLECT:
                if (r_cnt == w_last - ONE)
                    w_next = (r_op == OP_MUL) ? S_DONE : S_FIX;
            S_FIX:
                w_next = S_DONE;
            S_DONE:
                if (res_ready) w_next = S_IDLE;
            default:
                w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    always_ff @(posedge CLK_0 or negedge RESETN_0) begin
        if (!RESETN_0) begin
            r_state <= S_IDLE;
            r_op    <= OP_MUL;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_tag   <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_next;
            if (flush) begin
                r_acc <= '0;
            end else if (w_accept) begin
                r_op  <= op_e'(req_op);
                r_a   <= req_rs1;
                r_b   <= req_rs2;
                r_tag <= req_tag;
                r_cnt <= '0;
                r_acc <= '0;
            end else begin
                if (r_state == S_ISSUE || r_state == S_COLLECT)
                    r_cnt <= r_cnt + ONE;
                if (w_cap) begin
                    if (r_op == OP_MUL) r_res <= mul_p;
                    else r_acc <= r_acc + pp_term(w_k, mul_p);
                end
                if (w_hit) r_res <= w_fuse_lo;
                if (r_state == S_FIX) r_res <= w_fix_hi;
            end
        end
    end

    mul_hi_fixup u_fix (
        .i_hi (r_acc[63:32]),
        .i_a  (r_a),
        .i_b  (r_b),
        .i_op (r_op),
        .o_hi (w_fix_hi)
    );

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (w_issue) begin
            if (r_op == OP_MUL) begin
                mul_a = r_a;
                mul_b = r_b;
            end else begin
                unique case (r_cnt[1:0])
                    2'd0: begin mul_a = {16'b0, r_a[15:0]};  mul_b = {16'b0, r_b[15:0]};  end
                    2'd1: begin mul_a = {16'b0, r_a[15:0]};  mul_b = {16'b0, r_b[31:16]}; end
                    2'd2: begin mul_a = {16'b0, r_a[31:16]}; mul_b = {16'b0, r_b[15:0]};  end
                    2'd3: begin mul_a = {16'b0, r_a[31:16]}; mul_b = {16'b0, r_b[31:16]}; end
                endcase
            end
        end
    end

    assign mul_ce    = w_issue ||
                       ((r_state == S_COLLECT) && (r_cnt < w_last - ONE));
    assign req_ready = (r_state == S_IDLE) && !flush;
    assign res_valid = (r_state == S_DONE);
    assign res_data  = r_res;
    assign res_tag   = r_tag;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: scoreboard bench for mul_sequencer with a behavioural
// registered multiplier and a 64-bit arithmetic reference.
module tb_mul_sequencer;

    localparam int MUL_LAT = 1;
    localparam int TAG_W   = 5;
`ifdef MUL_FUSE_EN
    localparam bit FUSE = 1'b1;
`else
    localparam bit FUSE = 1'b0;
`endif

    logic             CLK_0     = 1'b0;
    logic             RESETN_0  = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op    = '0;
    logic [31:0]      req_rs1   = '0;
    logic [31:0]      req_rs2   = '0;
    logic [TAG_W-1:0] req_tag   = '0;
    logic             flush     = 1'b0;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic             mul_ce;
    logic [31:0]      mul_p;

    always #5 CLK_0 = ~CLK_0;

    mul_sequencer #(.MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
        .CLK_0     (CLK_0),
        .RESETN_0  (RESETN_0),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_tag   (req_tag),
        .flush     (flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_ce    (mul_ce),
        .mul_p     (mul_p)
    );

    // Registered multiplier: advances only when CE is high.
    logic [31:0] pipe [MUL_LAT];
    always @(posedge CLK_0) begin
        if (mul_ce) begin
            pipe[0] <= mul_a * mul_b;
            for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mul_p = pipe[MUL_LAT-1];

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        int               lat;
        int               ce;
        bit               hi;
        logic [31:0]      a;
        logic [31:0]      b;
        int               cyc;
    } exp_t;

    exp_t             q[$];
    exp_t             me;
    int               passes = 0;
    int               checks = 0;
    int               cyc    = 0;
    int               ce_cnt = 0;
    int               rr_mode = 0;
    bit               seen   = 1'b0;
    logic [31:0]      s_data;
    logic [TAG_W-1:0] s_tag;
    logic [TAG_W-1:0] tagc   = '0;
    bit               fz_v   = 1'b0;
    logic [31:0]      fz_a   = '0;
    logic [31:0]      fz_b   = '0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    endfunction

    // RV32M semantics straight from signed/unsigned 64-bit products.
    function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (op)
            2'd1:    r = sa * sb;
            2'd2:    r = sa * ub;
            default: r = 64'(a) * 64'(b);
        endcase
        return (op == 2'd0) ? r[31:0] : r[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    always @(posedge CLK_0) cyc++;

    initial forever begin
        @(posedge CLK_0);
        #1;
        if (rr_mode == 0)      res_ready = 1'b1;
        else if (rr_mode == 1) res_ready = 1'($urandom_range(0, 1));
        else                   res_ready = 1'b0;
    end

    // Monitor: latency, CE usage, hold stability and data/tag on consume.
    always @(negedge CLK_0) begin
        if (RESETN_0) begin
            if (mul_ce) ce_cnt++;
            if (res_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_result: got %h expected none", res_data);
                end else begin
                    if (!seen) begin
                        seen   = 1'b1;
                        s_data = res_data;
                        s_tag  = res_tag;
                        chk("latency", 32'(cyc - q[0].cyc), 32'(q[0].lat));
                        chk("ce_cycles", 32'(ce_cnt), 32'(q[0].ce));
                        chk("req_ready_in_done", 32'(req_ready), 32'd0);
                    end else begin
                        chk("hold_stable", 32'(res_data == s_data && res_tag == s_tag), 32'd1);
                    end
                    if (res_ready && !flush) begin
                        me = q.pop_front();
                        chk("res_data", res_data, me.data);
                        chk("res_tag", 32'(res_tag), 32'(me.tag));
                        seen = 1'b0;
                        if (me.hi) begin
                            fz_v = 1'b1;
                            fz_a = me.a;
                            fz_b = me.b;
                        end
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        exp_t e;
        int   n;
        bit   hit;
        n         = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = tagc;
        forever begin
            @(negedge CLK_0);
            if (req_ready) break;
            n++;
            if (n > 300) begin
                checks++;
                $display("FAIL accept_timeout: got no req_ready expected accept");
                req_valid = 1'b0;
                return;
            end
        end
        hit    = FUSE && (op == 2'd0) && fz_v && (a == fz_a) && (b == fz_b);
        e.data = ref_mul(op, a, b);
        e.tag  = tagc;
        e.lat  = hit ? 1 : (op == 2'd0) ? MUL_LAT + 1 : MUL_LAT + 5;
        e.ce   = hit ? 0 : (op == 2'd0) ? MUL_LAT : 3 + MUL_LAT;
        e.hi   = (op != 2'd0);
        e.a    = a;
        e.b    = b;
        e.cyc  = cyc + 1;
        q.push_back(e);
        ce_cnt = 0;
        tagc   = tagc + 1'b1;
        @(posedge CLK_0);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0) begin
            @(posedge CLK_0);
            #1;
            n++;
            if (n > 300) begin
                checks++;
                $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
                q.delete();
                seen = 1'b0;
            end
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_mul_ce", 32'(mul_ce), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_tag", 32'(res_tag), 32'd0);
        chk("rst_mul_a", mul_a, 32'd0);
        chk("rst_mul_b", mul_b, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;

        repeat (2) @(posedge CLK_0);
        #1;
        check_reset_vals();
        RESETN_0 = 1'b1;
        @(posedge CLK_0);
        #1;

        send(2'd0, 32'd7, 32'hFFFFFFFD);        wait_done();
        send(2'd1, 32'h80000000, 32'h80000000); wait_done();
        send(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_done();
        send(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_done();

        // Backpressure: hold the MULHU result, then a back-to-back MUL.
        rr_mode = 2;
        send(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        n = 0;
        while (!res_valid && n < 100) begin
            @(posedge CLK_0);
            #1;
            n++;
        end
        repeat (5) @(posedge CLK_0);
        #1;
        rr_mode = 0;
        send(2'd0, 32'h0001E240, 32'hFFFF8001);
        wait_done();

        // Flush in the third issue cycle of a MULH, new MULHU right after.
        send(2'd1, 32'h89ABCDEF, 32'h76543210);
        repeat (2) @(posedge CLK_0);
        #1;
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'd3;
        req_rs1   = 32'h00010000;
        req_rs2   = 32'h00010000;
        @(negedge CLK_0);
        chk("ready_low_on_flush", 32'(req_ready), 32'd0);
        q.delete();
        seen = 1'b0;
        fz_v = 1'b0;
        @(posedge CLK_0);
        #1;
        flush = 1'b0;
        chk("ce_off_after_flush", 32'(mul_ce), 32'd0);
        chk("valid_off_after_flush", 32'(res_valid), 32'd0);
        send(2'd3, 32'h00010000, 32'h00010000);
        wait_done();

        // Reset in the middle of a MULH.
        send(2'd1, 32'hDEADBEEF, 32'h12345678);
        repeat (2) @(posedge CLK_0);
        #1;
        RESETN_0 = 1'b0;
        #1;
        check_reset_vals();
        q.delete();
        seen = 1'b0;
        fz_v = 1'b0;
        @(posedge CLK_0);
        #1;
        RESETN_0 = 1'b1;
        send(2'd1, 32'hDEADBEEF, 32'h12345678);
        wait_done();

        // Operand reuse after a MULHU, then again after a flush.
        send(2'd3, 32'h12345678, 32'h9ABCDEF0); wait_done();
        send(2'd0, 32'h12345678, 32'h9ABCDEF0); wait_done();
        flush = 1'b1;
        fz_v  = 1'b0;
        @(posedge CLK_0);
        #1;
        flush = 1'b0;
        send(2'd0, 32'h12345678, 32'h9ABCDEF0); wait_done();

        // Random traffic with random result backpressure.
        rr_mode = 1;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            send(op, a, b);
            if (op != 2'd0 && $urandom_range(0, 2) == 0) send(2'd0, a, b);
        end
        wait_done();
        rr_mode = 0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
